// File: rtl/thor2024_pkg.sv
// Shared types for the BTB write scheduler: PC type, BTB entry layout, FSM states.
package thor2024_pkg;

    localparam int BTB_AW = 10;

    typedef logic [31:0] pc_address_t;

    typedef struct packed {
        logic        takb;
        pc_address_t pc;
        pc_address_t tgt;
    } btb_entry_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wrsched_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/thor2024_btb_wrfifo.sv
// Two-push, one-pop update queue; slot 0 lands before slot 1 when both push.
module thor2024_btb_wrfifo
    import thor2024_pkg::*;
#(
    parameter int QDEPTH = 8,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push0,
    input  logic          push1,
    input  btb_entry_t    din0,
    input  btb_entry_t    din1,
    input  logic          pop,
    output btb_entry_t    dout,
    output logic [CW-1:0] count
);

    btb_entry_t    mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr1;

    // slot 1 goes behind slot 0 only if slot 0 actually pushed
    assign wr_ptr1 = wr_ptr + PW'(push0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= din0;
        if (push1) mem[wr_ptr1] <= din1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

endmodule

// File: rtl/thor2024_btb_wrsched.sv
// BTB write scheduler: clears the table, then drains committed-branch updates.
// Optional THOR2024_BTB_NTUPD_EN also writes not-taken commits (takb=0).
//
// state | meaning
// CLEAR | writing zero to every BTB index, commits dropped
// RUN   | queueing commit updates and popping one per cycle
module thor2024_btb_wrsched
    import thor2024_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int AW     = BTB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_v0,
    input  logic          commit_v1,
    input  logic          commit_takb0,
    input  logic          commit_takb1,
    input  pc_address_t   commit_pc0,
    input  pc_address_t   commit_pc1,
    input  pc_address_t   commit_brtgt0,
    input  pc_address_t   commit_brtgt1,
    input  logic          flush_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output btb_entry_t    wr_data,
    output logic          busy,
    output logic          flush_done,
    output logic [15:0]   drop_cnt
);

    localparam int CW = $clog2(QDEPTH) + 1;

    wrsched_state_t state, state_n;
    logic [AW-1:0]  idx, idx_n;
    logic           wr_en_n, busy_n, flush_done_n;
    logic [AW-1:0]  wr_addr_n;
    btb_entry_t     wr_data_n;
    logic [1:0]     drops;
    logic           push0, push1, pop, fifo_clr;
    logic [CW:0]    free;
    logic [CW-1:0]  count;
    btb_entry_t     fifo_dout;
    btb_entry_t     ent0, ent1;
    logic           elig0, elig1, same_idx, want0, want1;

`ifdef THOR2024_BTB_NTUPD_EN
    assign elig0 = commit_v0;
    assign elig1 = commit_v1;
`else
    assign elig0 = commit_v0 & commit_takb0;
    assign elig1 = commit_v1 & commit_takb1;
`endif

    // the younger commit wins when both hit the same BTB index
    assign same_idx = elig0 & elig1 & (commit_pc0[AW-1:0] == commit_pc1[AW-1:0]);
    assign want0    = elig0 & ~same_idx;
    assign want1    = elig1;
    assign ent0     = '{takb: commit_takb0, pc: commit_pc0, tgt: commit_brtgt0};
    assign ent1     = '{takb: commit_takb1, pc: commit_pc1, tgt: commit_brtgt1};

    thor2024_btb_wrfifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push0 (push0),
        .push1 (push1),
        .din0  (ent0),
        .din1  (ent1),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            idx        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b1;
            flush_done <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            busy       <= busy_n;
            flush_done <= flush_done_n;
            drop_cnt   <= sat_add16(drop_cnt, drops);
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        wr_en_n      = 1'b0;
        wr_addr_n    = '0;
        wr_data_n    = '0;
        busy_n       = 1'b0;
        flush_done_n = 1'b0;
        push0        = 1'b0;
        push1        = 1'b0;
        pop          = 1'b0;
        fifo_clr     = 1'b0;
        drops        = 2'd0;
        free         = '0;
        case (state)
            CLEAR: begin
                busy_n   = 1'b1;
                fifo_clr = 1'b1;
                drops    = {1'b0, elig0} + {1'b0, elig1};
                if (flush_req) begin
                    idx_n = '0;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = idx;
                    idx_n     = idx + AW'(1);
                    if (idx == '1) begin
                        state_n      = RUN;
                        busy_n       = 1'b0;
                        flush_done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_n  = CLEAR;
                    idx_n    = '0;
                    busy_n   = 1'b1;
                    fifo_clr = 1'b1;
                    drops    = {1'b0, elig0} + {1'b0, elig1};
                end else begin
                    pop = (count != '0);
                    if (pop) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = fifo_dout.pc[AW-1:0];
                        wr_data_n = fifo_dout;
                    end
                    // the entry popped this cycle frees its slot for a push
                    free = (CW+1)'(QDEPTH) - {1'b0, count} + (CW+1)'(pop);
                    if (want0 && want1) begin
                        if (free >= (CW+1)'(2)) begin
                            push0 = 1'b1;
                            push1 = 1'b1;
                        end else if (free == (CW+1)'(1)) begin
                            push0 = 1'b1;
                            drops = 2'd1;
                        end else begin
                            drops = 2'd2;
                        end
                    end else if (want0) begin
                        if (free != '0) push0 = 1'b1;
                        else            drops = 2'd1;
                    end else if (want1) begin
                        if (free != '0) push1 = 1'b1;
                        else            drops = 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
